// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a
// time to instruction memory, and buffers returned words in a small FIFO
// that feeds the decode/execute datapath. Redirects flush the buffer and
// discard any response that is still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DROP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   raddr_q, raddr_d;
  logic          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic [31:0] rpc;
  logic        full, pop, push, space;

  assign rpc       = redirect_pc & 32'hFFFF_FFFC;
  assign full      = (cnt_q == DEPTH_C);
  assign ins_valid = (cnt_q != '0);
  assign pop       = ins_valid & ins_ready;
  // Room for one more entry once this cycle's pop and push have landed
  assign space     = ({1'b0, cnt_q} + (CW+1)'(1)) < ({1'b0, DEPTH_C} + (CW+1)'(pop));

  assign imem_req  = req_q;
  assign imem_addr = raddr_q;
  assign ins       = ins_valid ? ins_mem[rd_q] : 32'h0;
  assign ins_pc    = ins_valid ? pc_mem[rd_q]  : 32'h0;

  // Fetch control: request sequencing, redirect handling, push decision
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    raddr_d = raddr_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fpc_d = rpc;
        end else if (!full || pop) begin
          raddr_d = fpc_q;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          if (redirect) begin
            // Response belongs to the old path; restart at the target now
            raddr_d = rpc;
            fpc_d   = rpc;
          end else begin
            push  = 1'b1;
            fpc_d = raddr_q + 32'd4;
            if (space) raddr_d = raddr_q + 32'd4;
            else       state_d = IDLE;
          end
        end else if (redirect) begin
          // Request cannot be withdrawn: let it finish, then drop its data
          fpc_d   = rpc;
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          raddr_d = redirect ? rpc : fpc_q;
          fpc_d   = redirect ? rpc : fpc_q;
          state_d = BUSY;
        end else if (redirect) begin
          fpc_d = rpc;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d != IDLE);
  end

  // Buffer bookkeeping; a redirect empties it regardless of push/pop
  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (redirect) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      if (push) wr_d = (wr_q == LAST_C) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LAST_C) ? '0 : rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control and pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      raddr_q <= RESET_PC;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      raddr_q <= raddr_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Buffer storage; contents are qualified by the count so need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= raddr_q;
      ins_mem[wr_q] <= imem_rdata;
    end
  end

  // A push into a full buffer would overwrite the oldest instruction
  always @(posedge clk) begin
    if (rst_n) assert (!(push && full));
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run whose
// delivered instruction stream is checked against program-order rules.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0200;
  localparam int          DEPTH = 2;
  localparam logic [31:0] OFF   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ins_valid, ins_ready = 1'b0;
  logic [31:0] ins, ins_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc),
    .ins_ready(ins_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: returns addr+OFF after mem_lat wait cycles (-1 = random)
  int mem_lat   = 0;
  bit mem_hold  = 1'b0;
  bit stray_ack = 1'b0;
  int wait_cnt  = -1;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      imem_ack = stray_ack; imem_rdata = $urandom; wait_cnt = -1;
    end else if (imem_req) begin
      if (wait_cnt < 0) wait_cnt = (mem_lat < 0) ? int'($urandom_range(3, 0)) : mem_lat;
      if (wait_cnt == 0 && !mem_hold) begin
        imem_ack = 1'b1; imem_rdata = imem_addr + OFF; wait_cnt = -1;
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom;
        if (wait_cnt > 0) wait_cnt--;
      end
    end else begin
      imem_ack = stray_ack; imem_rdata = $urandom; wait_cnt = -1;
    end
  end

  // Monitor: records consumed instructions, redirects and handshakes
  typedef struct packed { logic redir; logic [31:0] pc; logic [31:0] ins; } ev_t;
  ev_t         ev_q[$];
  logic [31:0] hs_q[$];
  int          proto_err = 0, zero_err = 0;
  bit          p_ok = 0, p_req = 0, p_ack = 0;
  logic [31:0] p_addr = 32'h0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect) ev_q.push_back({1'b1, redirect_pc, 32'h0});
      else if (ins_valid && ins_ready) ev_q.push_back({1'b0, ins_pc, ins});
      if (imem_req && imem_ack) hs_q.push_back(imem_addr);
      if (p_ok && p_req && !p_ack && (!imem_req || imem_addr !== p_addr)) proto_err++;
      if (!ins_valid && (ins !== 32'h0 || ins_pc !== 32'h0)) zero_err++;
    end
    p_ok = rst_n; p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
  end

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ins_ready = 1'b0;
    mem_hold = 1'b0; stray_ack = 1'b0; mem_lat = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ev_q.delete(); hs_q.delete(); proto_err = 0; zero_err = 0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ins_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== RPC) begin n_errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
    n_checks++; if ({ins_valid, ins, ins_pc} !== 65'h0) begin n_errors++; $display("FAIL reset_ins: got v=%b ins=%h pc=%h want zeros", ins_valid, ins, ins_pc); end
    do_reset();
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0 || ins_valid !== 1'b0) begin n_errors++; $display("FAIL reset_release: got req=%b v=%b want 0 0", imem_req, ins_valid); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    do_reset(); mem_lat = 0; ins_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin n_errors++; $display("FAIL zw_first_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = RPC + 32'(4 * k);
      n_checks++;
      if ({ins_valid, ins_pc, ins, imem_req} !== {1'b1, e, e + OFF, 1'b1}) begin
        n_errors++; $display("FAIL zw_stream[%0d]: got v=%b pc=%h ins=%h req=%b want 1 %h %h 1", k, ins_valid, ins_pc, ins, imem_req, e, e + OFF);
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    do_reset(); mem_lat = 2; ins_ready = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (hs_q.size() != DEPTH) begin n_errors++; $display("FAIL bp_fetched: got %0d want %0d", hs_q.size(), DEPTH); end
    n_checks++; if ({ins_valid, ins_pc, ins, imem_req} !== {1'b1, RPC, RPC + OFF, 1'b0}) begin n_errors++; $display("FAIL bp_hold: got v=%b pc=%h ins=%h req=%b want 1 %h %h 0", ins_valid, ins_pc, ins, imem_req, RPC, RPC + OFF); end
    @(posedge clk); #1 ins_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (ins_valid !== 1'b1 || ins_pc !== RPC) begin n_errors++; $display("FAIL bp_pop0: got v=%b pc=%h want 1 %h", ins_valid, ins_pc, RPC); end
    @(negedge clk);
    n_checks++; if (ins_valid !== 1'b1 || ins_pc !== RPC + 32'd4) begin n_errors++; $display("FAIL bp_pop1: got v=%b pc=%h want 1 %h", ins_valid, ins_pc, RPC + 32'd4); end
    wait_valid(got);
    n_checks++; if (!got || ins_pc !== RPC + 32'd8) begin n_errors++; $display("FAIL bp_resume: got seen=%b pc=%h want 1 %h", got, ins_pc, RPC + 32'd8); end
  endtask

  task automatic test_redirect_pending();
    bit got;
    do_reset(); mem_lat = 0; mem_hold = 1'b1; ins_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin n_errors++; $display("FAIL rp_setup: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC); end
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h80;
    @(posedge clk); #1 redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if ({imem_req, imem_addr, ins_valid} !== {1'b1, RPC, 1'b0}) begin n_errors++; $display("FAIL rp_held[%0d]: got req=%b addr=%h v=%b want 1 %h 0", k, imem_req, imem_addr, ins_valid, RPC); end
    end
    mem_hold = 1'b0;
    wait_valid(got);
    n_checks++; if (!got || ins_pc !== 32'h80 || ins !== 32'h180) begin n_errors++; $display("FAIL rp_first: got seen=%b pc=%h ins=%h want 1 00000080 00000180", got, ins_pc, ins); end
    n_checks++; if (hs_q.size() < 2 || hs_q[0] !== RPC || hs_q[1] !== 32'h80) begin n_errors++; $display("FAIL rp_addrs: got n=%0d want %h then 00000080", hs_q.size(), RPC); end
  endtask

  task automatic test_redirect_full();
    bit got;
    do_reset(); mem_lat = 0; ins_ready = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if ({ins_valid, ins_pc, imem_req} !== {1'b1, RPC, 1'b0}) begin n_errors++; $display("FAIL rf_full: got v=%b pc=%h req=%b want 1 %h 0", ins_valid, ins_pc, imem_req, RPC); end
    @(posedge clk); #1 ins_ready = 1'b1;
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    n_checks++; if ({imem_req, imem_ack, ins_valid, ins_pc} !== {3'b111, RPC + 32'd4}) begin n_errors++; $display("FAIL rf_setup: got req=%b ack=%b v=%b pc=%h want 1 1 1 %h", imem_req, imem_ack, ins_valid, ins_pc, RPC + 32'd4); end
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    n_checks++; if ({ins_valid, imem_req, imem_addr} !== {2'b01, 32'h40}) begin n_errors++; $display("FAIL rf_flush: got v=%b req=%b addr=%h want 0 1 00000040", ins_valid, imem_req, imem_addr); end
    wait_valid(got);
    n_checks++; if (!got || ins_pc !== 32'h40 || ins !== 32'h140) begin n_errors++; $display("FAIL rf_first: got seen=%b pc=%h ins=%h want 1 00000040 00000140", got, ins_pc, ins); end
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset(); mem_lat = 0; ins_ready = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk); #1 ins_ready = 1'b0; mem_hold = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ins_valid !== 1'b1) begin n_errors++; $display("FAIL rm_setup: got v=%b want 1", ins_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({imem_req, imem_addr, ins_valid, ins, ins_pc} !== {1'b0, RPC, 1'b0, 64'h0}) begin n_errors++; $display("FAIL rm_async: got req=%b addr=%h v=%b ins=%h pc=%h want 0 %h 0 0 0", imem_req, imem_addr, ins_valid, ins, ins_pc, RPC); end
    stray_ack = 1'b1; mem_hold = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    hs_q.delete();
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin n_errors++; $display("FAIL rm_stray: got v=%b req=%b addr=%h want 0 1 %h", ins_valid, imem_req, imem_addr, RPC); end
    wait_valid(got);
    n_checks++; if (!got || ins_pc !== RPC || hs_q.size() < 1 || hs_q[0] !== RPC) begin n_errors++; $display("FAIL rm_restart: got seen=%b pc=%h want 1 %h", got, ins_pc, RPC); end
  endtask

  task automatic test_wrap();
    bit got;
    do_reset(); mem_lat = 0; ins_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1 redirect = 1'b0;
    wait_valid(got);
    n_checks++; if (!got || ins_pc !== 32'hFFFF_FFFC || ins !== 32'h0000_00FC) begin n_errors++; $display("FAIL wrap_top: got seen=%b pc=%h ins=%h want 1 fffffffc 000000fc", got, ins_pc, ins); end
    wait_valid(got);
    n_checks++; if (!got || ins_pc !== 32'h0 || ins !== 32'h100) begin n_errors++; $display("FAIL wrap_zero: got seen=%b pc=%h ins=%h want 1 00000000 00000100", got, ins_pc, ins); end
  endtask

  // Delivered stream must be program order from the last redirect target
  task automatic test_random();
    logic [31:0] exp;
    int pops, shown;
    do_reset(); mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      ins_ready   = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(15, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom);
    end
    @(posedge clk); #1 redirect = 1'b0; ins_ready = 1'b1;
    repeat (30) @(negedge clk);
    exp = RPC; pops = 0; shown = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].redir) exp = ev_q[i].pc & 32'hFFFF_FFFC;
      else begin
        n_checks++;
        if (ev_q[i].pc !== exp || ev_q[i].ins !== exp + OFF) begin
          n_errors++;
          if (shown < 10) $display("FAIL rnd_stream[%0d]: got pc=%h ins=%h want %h %h", i, ev_q[i].pc, ev_q[i].ins, exp, exp + OFF);
          shown++;
        end
        exp = exp + 32'd4; pops++;
      end
    end
    n_checks++; if (pops < 300) begin n_errors++; $display("FAIL rnd_progress: got %0d pops want >= 300", pops); end
    n_checks++; if (proto_err != 0) begin n_errors++; $display("FAIL rnd_req_protocol: got %0d violations want 0", proto_err); end
    n_checks++; if (zero_err != 0) begin n_errors++; $display("FAIL rnd_idle_zero: got %0d nonzero idle outputs want 0", zero_err); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_pending();
    test_redirect_full();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
